// File: rtl/wb_stage.sv
// MEM/WB register + write-back mux driving the regfile port; optional retire counter via WB_RETIRE_CNT_EN.
// Latency: 1 cycle from input sample to WE/rw/Din; Din is combinational from the registered entry.
// Backpressure: stall holds the entry (WE may stay high), flush beats stall, halt freezes retirement until reset.
module wb_stage #(
    parameter int WB_DATA_W = 32,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_regwrite,
    input  logic [4:0]           in_rw,
    input  logic [1:0]           in_wbsel,
    input  logic [2:0]           in_memfmt,
    input  logic [1:0]           in_addr_lo,
    input  logic [WB_DATA_W-1:0] in_alu,
    input  logic [WB_DATA_W-1:0] in_mem,
    input  logic [WB_DATA_W-1:0] in_pc,
    input  logic                 in_halt,
    output logic                 WE,
    output logic [4:0]           rw,
    output logic [WB_DATA_W-1:0] Din,
    output logic                 halted,
    output logic                 misalign,
    output logic [CNT_W-1:0]     retire_cnt
);

    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_LINK = 2'b10;

    localparam logic [2:0] FMT_LB  = 3'b001;
    localparam logic [2:0] FMT_LBU = 3'b010;
    localparam logic [2:0] FMT_LH  = 3'b011;
    localparam logic [2:0] FMT_LHU = 3'b100;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic [4:0]           rw;
        logic [1:0]           wbsel;
        logic [2:0]           memfmt;
        logic [1:0]           addr_lo;
        logic [WB_DATA_W-1:0] alu;
        logic [WB_DATA_W-1:0] mem;
        logic [WB_DATA_W-1:0] pc;
    } entry_t;

    entry_t entry_q, entry_d;
    logic   halted_q, halted_d;
    logic   load_en;

    assign load_en = !flush && !stall && !halted_q;

    always_comb begin
        entry_d  = entry_q;
        halted_d = halted_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (stall) begin
            entry_d = entry_q;
        end else if (halted_q) begin
            entry_d.valid = 1'b0;
        end else begin
            entry_d.valid    = in_valid;
            entry_d.regwrite = in_regwrite;
            entry_d.rw       = in_rw;
            entry_d.wbsel    = in_wbsel;
            entry_d.memfmt   = in_memfmt;
            entry_d.addr_lo  = in_addr_lo;
            entry_d.alu      = in_alu;
            entry_d.mem      = in_mem;
            entry_d.pc       = in_pc;
            // the halt entry itself still retires; only later loads become bubbles
            halted_d         = in_valid && in_halt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            halted_q <= halted_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_en && in_valid) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`else
    logic unused_load_en;
    assign unused_load_en = load_en;
    assign retire_cnt     = '0;
`endif

    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [WB_DATA_W-1:0] ld_dat;
    logic                 fmt_half;
    logic                 fmt_word;

    always_comb begin
        ld_byte = 8'h00;
        unique case (entry_q.addr_lo)
            2'd0:    ld_byte = entry_q.mem[7:0];
            2'd1:    ld_byte = entry_q.mem[15:8];
            2'd2:    ld_byte = entry_q.mem[23:16];
            default: ld_byte = entry_q.mem[31:24];
        endcase
        ld_half = entry_q.addr_lo[1] ? entry_q.mem[31:16] : entry_q.mem[15:0];

        fmt_half = (entry_q.memfmt == FMT_LH) || (entry_q.memfmt == FMT_LHU);
        fmt_word = !fmt_half && (entry_q.memfmt != FMT_LB) && (entry_q.memfmt != FMT_LBU);

        case (entry_q.memfmt)
            FMT_LB:  ld_dat = {{(WB_DATA_W-8){ld_byte[7]}}, ld_byte};
            FMT_LBU: ld_dat = {{(WB_DATA_W-8){1'b0}}, ld_byte};
            FMT_LH:  ld_dat = {{(WB_DATA_W-16){ld_half[15]}}, ld_half};
            FMT_LHU: ld_dat = {{(WB_DATA_W-16){1'b0}}, ld_half};
            default: ld_dat = entry_q.mem;
        endcase
    end

    always_comb begin
        misalign = entry_q.valid && (entry_q.wbsel == WBSEL_LOAD) &&
                   ((fmt_half && entry_q.addr_lo[0]) ||
                    (fmt_word && (entry_q.addr_lo != 2'b00)));

        case (entry_q.wbsel)
            WBSEL_LOAD: Din = ld_dat;
            WBSEL_LINK: Din = entry_q.pc + WB_DATA_W'(8);
            default:    Din = entry_q.alu;
        endcase

        WE = entry_q.valid && entry_q.regwrite && (entry_q.rw != 5'd0) && !misalign;
    end

    assign rw     = entry_q.rw;
    assign halted = halted_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: hand-computed write-back values, stall/flush, halt and async reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valid, in_regwrite;
    logic [4:0]  in_rw;
    logic [1:0]  in_wbsel;
    logic [2:0]  in_memfmt;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu, in_mem, in_pc;
    logic        in_halt;
    logic        WE;
    logic [4:0]  rw;
    logic [31:0] Din;
    logic        halted, misalign;
    logic [31:0] retire_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int n_ret       = 0;

    wb_stage #(.WB_DATA_W(32), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_regwrite(in_regwrite),
        .in_rw      (in_rw),
        .in_wbsel   (in_wbsel),
        .in_memfmt  (in_memfmt),
        .in_addr_lo (in_addr_lo),
        .in_alu     (in_alu),
        .in_mem     (in_mem),
        .in_pc      (in_pc),
        .in_halt    (in_halt),
        .WE         (WE),
        .rw         (rw),
        .Din        (Din),
        .halted     (halted),
        .misalign   (misalign),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return n_ret;
`else
        return 32'd0;
`endif
    endfunction

    task automatic drive(input logic v, input logic rgw, input logic [4:0] r,
                         input logic [1:0] sel, input logic [2:0] fmt, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic hlt);
        in_valid    = v;
        in_regwrite = rgw;
        in_rw       = r;
        in_wbsel    = sel;
        in_memfmt   = fmt;
        in_addr_lo  = lo;
        in_alu      = alu;
        in_mem      = mem;
        in_pc       = pc;
        in_halt     = hlt;
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".WE"},       {31'd0, WE},       32'd0);
        chk({tag, ".rw"},       {27'd0, rw},       32'd0);
        chk({tag, ".Din"},      Din,               32'd0);
        chk({tag, ".misalign"}, {31'd0, misalign}, 32'd0);
        chk({tag, ".halted"},   {31'd0, halted},   32'd0);
        chk({tag, ".cnt"},      retire_cnt,        32'd0);
    endtask

    // load from in_mem with given format/offset into r7 and check the extracted value
    task automatic load_vec(input string tag, input logic [2:0] fmt, input logic [1:0] lo,
                            input logic [31:0] exp);
        drive(1, 1, 5'd7, 2'b01, fmt, lo, 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 0);
        tick();
        n_ret++;
        chk({tag, ".Din"}, Din, exp);
        chk({tag, ".WE"},  {31'd0, WE}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(0, 0, 5'd0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        #2 rst_n = 1'b0;
        #5 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 1, 5'd5, 2'b00, 3'b000, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 0);
        tick();
        n_ret++;
        chk("alu.WE",  {31'd0, WE}, 32'd1);
        chk("alu.rw",  {27'd0, rw}, 32'd5);
        chk("alu.Din", Din, 32'h1234_5678);
        chk("alu.cnt", retire_cnt, exp_cnt());

        load_vec("lb3",   3'b001, 2'd3, 32'hFFFF_FF80);
        load_vec("lbu3",  3'b010, 2'd3, 32'h0000_0080);
        load_vec("lb1",   3'b001, 2'd1, 32'h0000_007F);
        load_vec("lh2",   3'b011, 2'd2, 32'hFFFF_80FF);
        load_vec("lhu0",  3'b100, 2'd0, 32'h0000_7F01);
        load_vec("lw0",   3'b000, 2'd0, 32'h80FF_7F01);
        load_vec("fmt7",  3'b111, 2'd0, 32'h80FF_7F01);

        drive(1, 1, 5'd31, 2'b10, 3'b000, 2'b00, 32'h1111_1111, 32'h0, 32'hFFFF_FFFC, 0);
        tick();
        n_ret++;
        chk("link.Din", Din, 32'h0000_0004);
        chk("link.WE",  {31'd0, WE}, 32'd1);
        chk("link.rw",  {27'd0, rw}, 32'd31);
        in_rw = 5'd0;
        tick();
        n_ret++;
        chk("link_r0.WE",  {31'd0, WE}, 32'd0);
        chk("link_r0.Din", Din, 32'h0000_0004);

        drive(1, 1, 5'd4, 2'b11, 3'b000, 2'b00, 32'hCAFE_F00D, 32'h0, 32'h40, 0);
        tick();
        n_ret++;
        chk("sel11.Din", Din, 32'hCAFE_F00D);

        drive(1, 1, 5'd8, 2'b01, 3'b011, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 0);
        tick();
        n_ret++;
        chk("mis_lh1.misalign", {31'd0, misalign}, 32'd1);
        chk("mis_lh1.WE",       {31'd0, WE},       32'd0);
        drive(1, 1, 5'd8, 2'b01, 3'b000, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 0);
        tick();
        n_ret++;
        chk("mis_lw2.misalign", {31'd0, misalign}, 32'd1);
        chk("mis_lw2.WE",       {31'd0, WE},       32'd0);
        chk("mis.cnt",          retire_cnt,        exp_cnt());

        drive(1, 1, 5'd9, 2'b00, 3'b000, 2'b00, 32'hAAAA_5555, 32'h0, 32'h0, 0);
        tick();
        n_ret++;
        stall = 1'b1;
        drive(1, 1, 5'd10, 2'b00, 3'b000, 2'b00, 32'hBBBB_0000, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.WE",  {31'd0, WE}, 32'd1);
            chk("stall.rw",  {27'd0, rw}, 32'd9);
            chk("stall.Din", Din, 32'hAAAA_5555);
        end
        flush = 1'b1;
        tick();
        chk("stflush.WE",  {31'd0, WE}, 32'd0);
        chk("stflush.cnt", retire_cnt, exp_cnt());
        stall = 1'b0;
        flush = 1'b0;

        drive(1, 1, 5'd2, 2'b00, 3'b000, 2'b00, 32'h0000_0042, 32'h0, 32'h0, 1);
        tick();
        n_ret++;
        chk("halt.WE",     {31'd0, WE},     32'd1);
        chk("halt.rw",     {27'd0, rw},     32'd2);
        chk("halt.Din",    Din,             32'h0000_0042);
        chk("halt.halted", {31'd0, halted}, 32'd1);
        drive(1, 1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h0000_0099, 32'h0, 32'h0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("post_halt.WE",     {31'd0, WE},     32'd0);
            chk("post_halt.halted", {31'd0, halted}, 32'd1);
            chk("post_halt.cnt",    retire_cnt,      exp_cnt());
        end

        #2 rst_n = 1'b0;
        n_ret = 0;
        #1 check_zero("midreset");
        #1 rst_n = 1'b1;

        drive(1, 1, 5'd6, 2'b00, 3'b000, 2'b00, 32'h0BAD_F00D, 32'h0, 32'h0, 0);
        tick();
        n_ret++;
        chk("resume.WE",  {31'd0, WE}, 32'd1);
        chk("resume.Din", Din, 32'h0BAD_F00D);
        chk("resume.cnt", retire_cnt, exp_cnt());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
